universal_reg: RTL and testbench

Parametrised multi-mode register: the clocked, multi-bit successor to the single-bit D storage element, used for the CPU's general-purpose, shift and counter registers. It holds a WIDTH-bit value and, per clock, can hold, parallel-load, shift, rotate, or (optionally) increment/decrement it. Serial-out and wrap flags let instances be chained into wider shifters and counters.

---
 rtl/universal_reg_pkg.sv | 13 +
 rtl/universal_reg_next.sv | 52 +++++
 rtl/universal_reg.sv | 42 ++++
 tb/tb_universal_reg.sv | 116 +++++++++++
 4 files changed

// File: rtl/universal_reg_pkg.sv
// universal_reg_pkg: mode codes shared by universal_reg and the control unit that drives mode
package universal_reg_pkg;
  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_INC  = 3'b110,
    M_DEC  = 3'b111
  } mode_t;
endpackage

// File: rtl/universal_reg_next.sv
// universal_reg_next: combinational next q/sout/co; INC/DEC only when UNIV_REG_COUNT_EN is defined
module universal_reg_next
  import universal_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q_nxt,
  output logic             sout_nxt,
  output logic             co_nxt
);
  mode_t m;
  assign m = mode_t'(mode);
  always_comb begin
    q_nxt    = q;
    sout_nxt = 1'b0;
    co_nxt   = 1'b0;
    case (m)
      M_LOAD: q_nxt = d;
      M_SHL: begin
        q_nxt    = {q[WIDTH-2:0], sin};
        sout_nxt = q[WIDTH-1];
      end
      M_SHR: begin
        q_nxt    = {sin, q[WIDTH-1:1]};
        sout_nxt = q[0];
      end
      M_ROL: begin
        q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
        sout_nxt = q[WIDTH-1];
      end
      M_ROR: begin
        q_nxt    = {q[0], q[WIDTH-1:1]};
        sout_nxt = q[0];
      end
`ifdef UNIV_REG_COUNT_EN
      M_INC: begin
        q_nxt  = q + WIDTH'(1);
        co_nxt = &q;
      end
      M_DEC: begin
        q_nxt  = q - WIDTH'(1);
        co_nxt = ~|q;
      end
`endif
      default: q_nxt = q;
    endcase
  end
endmodule

// File: rtl/universal_reg.sv
// universal_reg: multi-mode WIDTH-bit register (hold/load/shift/rotate, INC/DEC under UNIV_REG_COUNT_EN)
module universal_reg
  import universal_reg_pkg::*;
#(
  parameter int             WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             co
);
  logic [WIDTH-1:0] q_nxt;
  logic             sout_nxt;
  logic             co_nxt;
  universal_reg_next #(.WIDTH(WIDTH)) u_next (
    .q        (q),
    .mode     (mode),
    .d        (d),
    .sin      (sin),
    .q_nxt    (q_nxt),
    .sout_nxt (sout_nxt),
    .co_nxt   (co_nxt)
  );
  // reset beats enable; a disabled edge still clears the sout/co pulses
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q    <= RESET_VAL;
      sout <= 1'b0;
      co   <= 1'b0;
    end else begin
      q    <= en ? q_nxt : q;
      sout <= en & sout_nxt;
      co   <= en & co_nxt;
    end
  end
endmodule

// File: tb/tb_universal_reg.sv
// tb_universal_reg: directed checks of universal_reg, expectations follow UNIV_REG_COUNT_EN
module tb_universal_reg;
  import universal_reg_pkg::*;
`ifdef UNIV_REG_COUNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic       en = 1'b1;
  logic [2:0] mode = M_HOLD;
  logic [7:0] d = 8'h00;
  logic       sin = 1'b0;
  logic [7:0] q, qa;
  logic       sout, co, sout_a, co_a;
  int         checks = 0;
  int         errors = 0;

  universal_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .clr_n(clr_n), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(q), .sout(sout), .co(co)
  );
  universal_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut_a (
    .clk(clk), .clr_n(clr_n), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(qa), .sout(sout_a), .co(co_a)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r_n, input logic e, input logic [2:0] m,
                     input logic [7:0] dv, input logic s);
    clr_n = r_n;
    en    = e;
    mode  = m;
    d     = dv;
    sin   = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(1'b0, 1'b1, M_LOAD, 8'hFF, 1'b0);
    check("rst_q", q, 8'h00);
    check("rst_sout", {7'd0, sout}, 8'h00);
    check("rst_co", {7'd0, co}, 8'h00);
    check("rst_qa", qa, 8'hA5);
    check("rst_co_a", {7'd0, co_a}, 8'h00);

    cyc(1'b1, 1'b1, M_LOAD, 8'h3C, 1'b0);
    check("load", q, 8'h3C);
    cyc(1'b1, 1'b1, M_HOLD, 8'hFF, 1'b0);
    check("hold", q, 8'h3C);
    cyc(1'b1, 1'b0, M_LOAD, 8'h11, 1'b0);
    check("en0", q, 8'h3C);

    cyc(1'b1, 1'b1, M_LOAD, 8'h81, 1'b0);
    cyc(1'b1, 1'b1, M_SHL, 8'h00, 1'b0);
    check("shl_q", q, 8'h02);
    check("shl_sout", {7'd0, sout}, 8'h01);
    cyc(1'b1, 1'b1, M_SHR, 8'h00, 1'b1);
    check("shr_q", q, 8'h81);
    check("shr_sout", {7'd0, sout}, 8'h00);

    cyc(1'b1, 1'b1, M_ROL, 8'h00, 1'b0);
    check("rol_q", q, 8'h03);
    check("rol_sout", {7'd0, sout}, 8'h01);
    cyc(1'b1, 1'b1, M_ROR, 8'h00, 1'b0);
    check("ror_q", q, 8'h81);
    check("ror_sout", {7'd0, sout}, 8'h01);
    cyc(1'b1, 1'b0, M_ROR, 8'h00, 1'b0);
    check("en0_q", q, 8'h81);
    check("en0_sout", {7'd0, sout}, 8'h00);
    cyc(1'b1, 1'b1, M_SHR, 8'h00, 1'b1);
    cyc(1'b1, 1'b1, M_LOAD, 8'h44, 1'b0);
    check("load_sout", {7'd0, sout}, 8'h00);

    cyc(1'b1, 1'b1, M_LOAD, 8'hFE, 1'b0);
    cyc(1'b1, 1'b1, M_INC, 8'h00, 1'b0);
    check("inc1_q", q, CNT ? 8'hFF : 8'hFE);
    check("inc1_co", {7'd0, co}, 8'h00);
    cyc(1'b1, 1'b1, M_INC, 8'h00, 1'b0);
    check("inc2_q", q, CNT ? 8'h00 : 8'hFE);
    check("inc2_co", {7'd0, co}, CNT ? 8'h01 : 8'h00);
    cyc(1'b1, 1'b1, M_HOLD, 8'h00, 1'b0);
    check("hold_co", {7'd0, co}, 8'h00);
    cyc(1'b1, 1'b1, M_LOAD, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, M_DEC, 8'h00, 1'b0);
    check("dec_q", q, CNT ? 8'hFF : 8'h00);
    check("dec_co", {7'd0, co}, CNT ? 8'h01 : 8'h00);
    cyc(1'b1, 1'b1, M_LOAD, 8'h05, 1'b0);
    cyc(1'b1, 1'b1, M_INC, 8'h00, 1'b0);
    check("inc5_q", q, CNT ? 8'h06 : 8'h05);
    check("inc5_co", {7'd0, co}, 8'h00);

    cyc(1'b1, 1'b1, M_LOAD, 8'hFF, 1'b0);
    cyc(1'b0, 1'b1, M_INC, 8'h00, 1'b0);
    check("rst_mid_q", q, 8'h00);
    check("rst_mid_co", {7'd0, co}, 8'h00);
    check("rst_mid_qa", qa, 8'hA5);
    cyc(1'b1, 1'b1, M_INC, 8'h00, 1'b0);
    check("post_rst_q", q, CNT ? 8'h01 : 8'h00);
    check("post_rst_qa", qa, CNT ? 8'hA6 : 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
